// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one mode-0 SPI bus (SCLK/MOSI/CS) between a flash and a sensor master.
// Define SPI_BUS_ARBITER_TIMEOUT_EN to bound each grant to TIMEOUT rising edges with a sticky ERROR flag.
module spi_bus_arbiter #(
    parameter int CLK_DIV  = 50,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic CLK,
    input  logic RESET,
    input  logic REQ_FLASH,
    input  logic REQ_SENSOR,
    output logic GNT_FLASH,
    output logic GNT_SENSOR,
    input  logic MOSI_FLASH,
    input  logic MOSI_SENSOR,
    output logic MOSI,
    output logic SCLK,
    output logic SCLK_RISE,
    output logic SCLK_FALL,
    output logic FLASH_CS,
    output logic SENSOR_CS,
    output logic ERROR
);

    generate
        if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("spi_bus_arbiter: CLK_DIV must be 1..255");
        end
        if (CS_SETUP < 1 || CS_SETUP > 15) begin : g_bad_cs_setup
            $error("spi_bus_arbiter: CS_SETUP must be 1..15");
        end
        if (CS_HOLD < 1 || CS_HOLD > 15) begin : g_bad_cs_hold
            $error("spi_bus_arbiter: CS_HOLD must be 1..15");
        end
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("spi_bus_arbiter: TIMEOUT must be 1..65535");
        end
    endgenerate

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

    state_t     state_reg, state_next;
    logic       owner_reg, owner_next;   // 0 = flash, 1 = sensor
    logic       last_reg, last_next;     // requester granted most recently
    logic [3:0] phase_reg, phase_next;
    logic [7:0] div_reg, div_next;
    logic       sclk_reg, sclk_next;
    logic       rise_reg, rise_next;
    logic       fall_reg, fall_next;
    logic       stop_reg, stop_next;

    logic [1:0] req_vec;
    logic [1:0] mosi_vec;
    logic [1:0] sel_vec;
    logic [1:0] gnt_vec;
    logic       owner_req;
    logic       release_now;
    logic       pick;

    assign req_vec  = {REQ_SENSOR, REQ_FLASH};
    assign mosi_vec = {MOSI_SENSOR, MOSI_FLASH};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign sel_vec[gi] = (state_reg != IDLE) && (owner_reg == 1'(gi));
            assign gnt_vec[gi] = sel_vec[gi] && (state_reg == ACTIVE);
        end
    endgenerate

    assign owner_req   = req_vec[owner_reg];
    // Once the owner lets go (or the grant times out) the transaction is wound down for good.
    assign release_now = stop_reg | ~owner_req;
    assign pick        = (REQ_FLASH & REQ_SENSOR) ? ~last_reg : REQ_SENSOR;

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] EDGE_LIMIT = 16'(TIMEOUT);

    logic [15:0] edge_reg, edge_next;
    logic        error_reg, error_next;
    logic [15:0] edge_inc;

    assign edge_inc = edge_reg + 16'd1;
`endif

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        phase_next = phase_reg;
        div_next   = div_reg;
        sclk_next  = sclk_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        stop_next  = stop_reg;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
        edge_next  = edge_reg;
        error_next = error_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (REQ_FLASH || REQ_SENSOR) begin
                    state_next = SETUP;
                    owner_next = pick;
                    last_next  = pick;
                    phase_next = 4'd0;
                    stop_next  = 1'b0;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
                    edge_next  = 16'd0;
`endif
                end
            end
            SETUP: begin
                stop_next = release_now;
                if (phase_reg == SETUP_LAST) begin
                    phase_next = 4'd0;
                    if (release_now) begin
                        state_next = HOLD;
                    end else begin
                        state_next = ACTIVE;
                        div_next   = 8'd0;
                        sclk_next  = 1'b0;
                    end
                end else begin
                    phase_next = phase_reg + 4'd1;
                end
            end
            ACTIVE: begin
                if (!owner_req) begin
                    stop_next = 1'b1;
                end
                if (!sclk_reg && release_now) begin
                    state_next = HOLD;
                    phase_next = 4'd0;
                end else if (div_reg == DIV_LAST) begin
                    div_next  = 8'd0;
                    sclk_next = ~sclk_reg;
                    if (sclk_reg) begin
                        // The falling edge closing the last bit coincides with HOLD entry.
                        fall_next = 1'b1;
                        if (release_now) begin
                            state_next = HOLD;
                            phase_next = 4'd0;
                        end
                    end else begin
                        rise_next = 1'b1;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
                        edge_next = edge_inc;
                        if (edge_inc == EDGE_LIMIT) begin
                            stop_next  = 1'b1;
                            error_next = 1'b1;
                        end
`endif
                    end
                end else begin
                    div_next = div_reg + 8'd1;
                end
            end
            HOLD: begin
                if (phase_reg == HOLD_LAST) begin
                    state_next = IDLE;
                    phase_next = 4'd0;
                end else begin
                    phase_next = phase_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            phase_reg <= 4'd0;
            div_reg   <= 8'd0;
            sclk_reg  <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            stop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            phase_reg <= phase_next;
            div_reg   <= div_next;
            sclk_reg  <= sclk_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            stop_reg  <= stop_next;
        end
    end

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            edge_reg  <= 16'd0;
            error_reg <= 1'b0;
        end else begin
            edge_reg  <= edge_next;
            error_reg <= error_next;
        end
    end

    assign ERROR = error_reg;
`else
    assign ERROR = 1'b0;
`endif

    assign GNT_FLASH  = gnt_vec[0];
    assign GNT_SENSOR = gnt_vec[1];
    assign FLASH_CS   = ~sel_vec[0];
    assign SENSOR_CS  = ~sel_vec[1];
    assign MOSI       = |(gnt_vec & mosi_vec);
    assign SCLK       = sclk_reg;
    assign SCLK_RISE  = rise_reg;
    assign SCLK_FALL  = fall_reg;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter (CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, TIMEOUT=8): a table of single-requester
// transactions, then hand-written round-robin, timeout and mid-transaction reset sequences.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int TIMEOUT  = 8;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    localparam int LONG_N = 6;
`else
    localparam int LONG_N = 16;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req_flash = 1'b0, req_sensor = 1'b0;
    logic mosi_flash = 1'b0, mosi_sensor = 1'b0;
    logic gnt_flash, gnt_sensor, mosi, sclk, sclk_rise, sclk_fall, flash_cs, sensor_cs, error;

    always #5 clk = ~clk;

    spi_bus_arbiter #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk), .RESET(reset),
        .REQ_FLASH(req_flash), .REQ_SENSOR(req_sensor),
        .GNT_FLASH(gnt_flash), .GNT_SENSOR(gnt_sensor),
        .MOSI_FLASH(mosi_flash), .MOSI_SENSOR(mosi_sensor),
        .MOSI(mosi), .SCLK(sclk), .SCLK_RISE(sclk_rise), .SCLK_FALL(sclk_fall),
        .FLASH_CS(flash_cs), .SENSOR_CS(sensor_cs), .ERROR(error)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int overlap = 0, mosi_err = 0;
    logic prev_fcs = 1'b1, prev_scs = 1'b1;

    int n_rise, n_fall, f_low, s_low, gf, gs;
    int first_rise, last_rise, last_fall, first_gnt;
    int cs_fall, cs_rise, f_rise, s_fall, rel_rises, rel_gnt;
    int err_drop;
    bit err_seen;
    int grant_log[$];

    typedef struct {
        int sel;          // 0 flash, 1 sensor
        int mode;         // 0 one-cycle pulse, 1 drop at n-th rise, 2 drop at n-th fall
        int n;
        int exp_rises;
        int exp_gnt;      // cycles with the owner's GNT high
        int exp_cs_low;   // cycles with the owner's CS low
        int exp_hold_gap; // cycles from last SCLK fall to CS high
    } txn_t;

    txn_t tbl[6];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_stats();
        n_rise = 0; n_fall = 0; f_low = 0; s_low = 0; gf = 0; gs = 0;
        first_rise = -1; last_rise = -1; last_fall = -1; first_gnt = -1;
        cs_fall = -1; cs_rise = -1; f_rise = -1; s_fall = -1;
        rel_rises = -1; rel_gnt = -1; err_drop = 0; err_seen = 1'b0;
        grant_log.delete();
    endtask

    // Advance one cycle, sample outputs at the falling edge, then refresh the MOSI sources.
    task automatic tick();
        logic exp_mosi;
        @(negedge clk);
        cyc++;
        if (sclk_rise) begin
            n_rise++;
            last_rise = cyc;
            if (first_rise < 0) first_rise = cyc;
        end
        if (sclk_fall) begin
            n_fall++;
            last_fall = cyc;
        end
        if (!flash_cs) f_low++;
        if (!sensor_cs) s_low++;
        if (!flash_cs && !sensor_cs) overlap++;
        if (gnt_flash) gf++;
        if (gnt_sensor) gs++;
        if ((gnt_flash || gnt_sensor) && first_gnt < 0) first_gnt = cyc;
        exp_mosi = gnt_flash ? mosi_flash : (gnt_sensor ? mosi_sensor : 1'b0);
        if (mosi !== exp_mosi) mosi_err++;
        if (prev_fcs && !flash_cs) begin
            grant_log.push_back(0);
            if (cs_fall < 0) cs_fall = cyc;
        end
        if (prev_scs && !sensor_cs) begin
            grant_log.push_back(1);
            if (cs_fall < 0) cs_fall = cyc;
            if (s_fall < 0) s_fall = cyc;
        end
        if ((!prev_fcs && flash_cs) || (!prev_scs && sensor_cs)) begin
            if (cs_rise < 0) begin
                cs_rise = cyc;
                rel_rises = n_rise;
                rel_gnt = gf + gs;
            end
        end
        if (!prev_fcs && flash_cs && f_rise < 0) f_rise = cyc;
        if (err_seen && !error) err_drop++;
        if (error) err_seen = 1'b1;
        prev_fcs = flash_cs;
        prev_scs = sensor_cs;
        mosi_flash = 1'($urandom_range(0, 1));
        mosi_sensor = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_rises(input int n, input string name);
        int budget = 400;
        while (n_rise < n && budget > 0) begin
            tick();
            budget--;
        end
        if (n_rise < n) check(name, n_rise, n);
    endtask

    task automatic wait_falls(input int n, input string name);
        int budget = 400;
        while (n_fall < n && budget > 0) begin
            tick();
            budget--;
        end
        if (n_fall < n) check(name, n_fall, n);
    endtask

    task automatic do_reset();
        reset = 1'b0; req_flash = 1'b0; req_sensor = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        tbl[0] = '{0, 1, LONG_N, LONG_N, 4 * LONG_N, 4 * LONG_N + 4, 2};
        tbl[1] = '{1, 1, 3, 3, 12, 16, 2};
        tbl[2] = '{0, 0, 0, 0, 0, 4, 0};
        tbl[3] = '{1, 0, 0, 0, 0, 4, 0};
        tbl[4] = '{0, 2, 2, 2, 9, 13, 3};
        tbl[5] = '{1, 1, 1, 1, 4, 8, 2};

        clear_stats();
        tick();
        check("rst_flash_cs", int'(flash_cs), 1);
        check("rst_sensor_cs", int'(sensor_cs), 1);
        check("rst_sclk", int'(sclk), 0);
        check("rst_gnt", int'({gnt_flash, gnt_sensor}), 0);
        check("rst_pulses", int'({sclk_rise, sclk_fall}), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_error", int'(error), 0);
        reset = 1'b1;
        tick(); tick();

        for (int i = 0; i < 6; i++) begin
            clear_stats();
            if (tbl[i].sel == 0) req_flash = 1'b1; else req_sensor = 1'b1;
            if (tbl[i].mode == 0) tick();
            else if (tbl[i].mode == 1) wait_rises(tbl[i].n, "txn_wait_rise");
            else wait_falls(tbl[i].n, "txn_wait_fall");
            req_flash = 1'b0;
            req_sensor = 1'b0;
            repeat (12) tick();
            check("txn_rises", n_rise, tbl[i].exp_rises);
            check("txn_falls", n_fall, tbl[i].exp_rises);
            check("txn_own_gnt", (tbl[i].sel == 0) ? gf : gs, tbl[i].exp_gnt);
            check("txn_other_gnt", (tbl[i].sel == 0) ? gs : gf, 0);
            check("txn_own_cs_low", (tbl[i].sel == 0) ? f_low : s_low, tbl[i].exp_cs_low);
            check("txn_other_cs_low", (tbl[i].sel == 0) ? s_low : f_low, 0);
            if (tbl[i].exp_rises > 0) begin
                check("txn_setup_gap", first_gnt - cs_fall, CS_SETUP);
                check("txn_first_rise", first_rise - first_gnt, CLK_DIV);
                check("txn_hold_gap", cs_rise - last_fall, tbl[i].exp_hold_gap);
                if (tbl[i].mode == 1) check("txn_fall_at_div", last_fall - last_rise, CLK_DIV);
            end
            $display("txn %0d: sel=%0d mode=%0d rises=%0d gnt=%0d cs_low=%0d/%0d", i, tbl[i].sel,
                     tbl[i].mode, n_rise, (tbl[i].sel == 0) ? gf : gs, f_low, s_low);
        end

        // Simultaneous requests: flash first after reset, then strict alternation.
        do_reset();
        clear_stats();
        req_flash = 1'b1; req_sensor = 1'b1;
        wait_rises(1, "rr1_flash_wait");
        req_flash = 1'b0;
        wait_rises(2, "rr1_sensor_wait");
        req_sensor = 1'b0;
        repeat (12) tick();
        check("rr_idle_gap", s_fall - f_rise, 1);
        req_flash = 1'b1; req_sensor = 1'b1;
        wait_rises(3, "rr2_wait");
        req_flash = 1'b0; req_sensor = 1'b0;
        repeat (12) tick();
        req_flash = 1'b1; req_sensor = 1'b1;
        wait_rises(4, "rr3_wait");
        req_flash = 1'b0; req_sensor = 1'b0;
        repeat (12) tick();
        check("rr_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("rr_grant0_flash", grant_log[0], 0);
            check("rr_grant1_sensor", grant_log[1], 1);
            check("rr_grant2_flash", grant_log[2], 0);
            check("rr_grant3_sensor", grant_log[3], 1);
        end
        $display("txn rr: grants=%0d rises=%0d", grant_log.size(), n_rise);

        // Flash request held indefinitely.
        do_reset();
        clear_stats();
        req_flash = 1'b1;
        repeat (200) tick();
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
        check("to_rises_per_grant", rel_rises, TIMEOUT);
        check("to_gnt_cycles", rel_gnt, 4 * TIMEOUT);
        check("to_error_set", int'(error), 1);
        check("to_error_sticky", err_drop, 0);
`else
        check("nto_rises", n_rise, 49);
        check("nto_no_release", cs_rise, -1);
        check("nto_error_low", int'(err_seen), 0);
`endif
        req_flash = 1'b0;
        repeat (12) tick();
        $display("txn hold: rises=%0d error=%0d", n_rise, error);

        // Reset mid-ACTIVE aborts at once and restores flash priority.
        do_reset();
        check("rst_clears_error", int'(error), 0);
        clear_stats();
        req_flash = 1'b1;
        wait_rises(2, "mid_rst_wait");
        reset = 1'b0;
        tick();
        check("mid_rst_flash_cs", int'(flash_cs), 1);
        check("mid_rst_sclk", int'(sclk), 0);
        check("mid_rst_gnt", int'(gnt_flash), 0);
        check("mid_rst_sensor_cs", int'(sensor_cs), 1);
        reset = 1'b1;
        req_flash = 1'b0;
        tick(); tick();
        req_flash = 1'b1; req_sensor = 1'b1;
        tick(); tick();
        check("post_rst_flash_cs", int'(flash_cs), 0);
        check("post_rst_sensor_cs", int'(sensor_cs), 1);
        req_flash = 1'b0; req_sensor = 1'b0;
        repeat (12) tick();
        $display("txn reset: flash_cs=%0d sensor_cs=%0d", flash_cs, sensor_cs);

        check("cs_never_both_low", overlap, 0);
        check("mosi_select", mosi_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
